la_mailbox_responder: RTL and testbench
=======================================

// Module: la_mailbox_responder
// PURPOSE
//  User-project end of a logic-analyzer (LA) mailbox. Management firmware writes command words onto
//  la_data_in and signals each one with a toggle. This block executes the command against a local
//  accumulator, counter and checkpoint register, then returns the result and an ack toggle on
//  la_data_out. CHECKPOINT drives 16-bit progress codes onto mprj_io[31:16] for the bench monitor.
//  The block sits inside user_project_wrapper, between the LA bus and the io_out/io_oeb pins.
// PARAMETERS
//  DATA_W     32  accumulator, counter and operand width (la_data_in[DATA_W-1:0])
//  SYNC_STG    2  synchroniser flops on the req toggle (>=2)
//  CKPT_LSB   16  lowest mprj_io bit driven by CHECKPOINT (16 bits wide)
// PORTS
//  wb_clk_i     in   1    the single clock; all logic is on its rising edge
//  resetb       in   1    asynchronous, active-low reset
//  la_data_in   in   128  [31:0] operand, [35:32] opcode, [36] req toggle
//  la_oenb      in   128  bit low = mgmt drives that bit; [36:0] must all be low for req to be seen
//  la_data_out  out  128  [31:0] result, [35:32] status, [36] ack toggle, [37] busy, rest 0
//  io_out       out  38   [CKPT_LSB+15:CKPT_LSB] checkpoint code; other bits 0
//  io_oeb       out  38   active-low output enable; all 1 until the first CHECKPOINT
// BEHAVIOUR
//  Reset: all outputs 0 except io_oeb (all 1). Reset clears acc, cnt, cnt_en, ckpt and req_seen.
//   FSM returns to IDLE. Reset mid-command drops that command with no ack.
//  req path: req_raw = la_data_in[36] when la_oenb[36:0]==0; otherwise req_raw holds its last value.
//   req_raw goes through SYNC_STG flops to give req_s.
//  FSM IDLE: when req_s != req_seen, latch opcode and operand, set req_seen<=req_s, go to EXEC.
//   Otherwise stay in IDLE.
//  FSM EXEC (1 cycle): execute the command, register result and status onto la_data_out, go to RESP.
//  FSM RESP (1 cycle): toggle ack (la_data_out[36]), go to IDLE.
//  busy = (state != IDLE).
//  Latency (SYNC_STG=2): edge 0 = first edge sampling the new req value. Command latched at edge 2,
//   result/status valid at edge 3, ack toggles at edge 4. Earliest next accept is edge 5.
//  Result and status hold until the next EXEC.
//  Req toggled while busy: stays pending and is accepted on the first IDLE cycle.
//   A double toggle while busy cancels itself. Firmware must wait for ack; this is not detected.
//  Opcodes (status 0=OK, 1=OVF, 2=BADOP):
//   0 NOP         result=acc
//   1 LOAD        acc=operand; result=operand
//   2 ADD         acc=(acc+operand) mod 2^DATA_W; result=new acc; status=1 on carry-out, else 0
//   3 READ        result=acc
//   4 CNT_START   cnt<=0, cnt_en<=1; result=0
//   5 CNT_STOP    cnt_en<=0; result=cnt
//   6 CNT_READ    result=cnt as sampled in the EXEC cycle
//   7 CHECKPOINT  ckpt=operand[15:0]; io_out[CKPT_LSB+:16]=ckpt from edge 3;
//                 io_oeb[CKPT_LSB+:16]=0 from then on (sticky until reset); result=operand
//   8-15          no state change; result=acc; status=2
//  Counter: cnt increments by 1 every cycle while cnt_en=1 and wraps at 2^DATA_W.
//   CNT_START in EXEC of edge t gives cnt=0 at t and k at t+k.
//  la_oenb[36:0] not all low: no new command is accepted. A command already in flight completes.
// TESTING
//  1 LOAD 0x0000_1234, then READ -> result 0x0000_1234, status 0; ack toggles 4 edges after each req.
//  2 LOAD 0xFFFF_FFFF, then ADD 0x2 -> result 0x0000_0001, status 1;
//    a following READ -> 0x0000_0001, status 0.
//  3 CHECKPOINT 0xAB60, then CHECKPOINT 0xAB61 -> mprj_io[31:16] reads 0xAB60 then 0xAB61;
//    io_oeb[31:16]=0, all other io_oeb bits 1.
//  4 Opcode 0xF with acc=0x55 -> status 2, result 0x55, acc unchanged.
//    Toggle req with la_oenb[36]=1 -> no ack for 50 cycles.
//  5 CNT_START; issue CNT_READ so its EXEC edge is 100 edges after the CNT_START EXEC edge
//    -> result 100. CNT_STOP then CNT_READ -> same value twice.
//  6 Assert resetb low at the EXEC edge of a LOAD 0x77 -> la_data_out=0, io_oeb all 1, acc=0, no ack.
//    After release, READ -> result 0.

Source files
------------

// File: rtl/la_mailbox_responder.sv
// User-project end of the LA mailbox: synchronises the firmware req toggle, executes one
// command against the accumulator/counter/checkpoint state and returns result, status and ack.
module la_mailbox_responder #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SYNC_STG = 2,
  parameter int unsigned CKPT_LSB = 16
) (
  input  logic         wb_clk_i,
  input  logic         resetb,
  input  logic [127:0] la_data_in,
  input  logic [127:0] la_oenb,
  output logic [127:0] la_data_out,
  output logic [37:0]  io_out,
  output logic [37:0]  io_oeb
);

  localparam int unsigned OP_W     = 4;
  localparam int unsigned ST_W     = 4;
  localparam int unsigned CKPT_W   = 16;
  localparam int unsigned OP_LSB   = 32;
  localparam int unsigned REQ_BIT  = 36;
  localparam int unsigned BUSY_BIT = 37;

  localparam logic [OP_W-1:0] OP_NOP       = 4'd0;
  localparam logic [OP_W-1:0] OP_LOAD      = 4'd1;
  localparam logic [OP_W-1:0] OP_ADD       = 4'd2;
  localparam logic [OP_W-1:0] OP_READ      = 4'd3;
  localparam logic [OP_W-1:0] OP_CNT_START = 4'd4;
  localparam logic [OP_W-1:0] OP_CNT_STOP  = 4'd5;
  localparam logic [OP_W-1:0] OP_CNT_READ  = 4'd6;
  localparam logic [OP_W-1:0] OP_CKPT      = 4'd7;

  localparam logic [ST_W-1:0] ST_OK    = 4'd0;
  localparam logic [ST_W-1:0] ST_OVF   = 4'd1;
  localparam logic [ST_W-1:0] ST_BADOP = 4'd2;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e              state_q, state_d;
  logic [SYNC_STG-1:0] sync_q;
  logic                req_seen_q, req_seen_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   opd_q, opd_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   cnt_q, cnt_d;
  logic                cnt_en_q, cnt_en_d;
  logic [CKPT_W-1:0]   ckpt_q, ckpt_d;
  logic                ckpt_oe_q, ckpt_oe_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [ST_W-1:0]     status_q, status_d;
  logic                ack_q, ack_d;
  logic                busy_q, busy_d;

  logic                req_gate_c, req_raw_c, req_s_c;
  logic [DATA_W:0]     sum_c;
  logic [DATA_W-1:0]   cnt_inc_c;
  logic                unused_la_c;

  assign unused_la_c = ^{la_data_in[127:REQ_BIT+1], la_oenb[127:REQ_BIT+1]};

  // Req toggle is only observed while mgmt drives the whole command field; otherwise hold it.
  assign req_gate_c = (la_oenb[REQ_BIT:0] == '0);
  assign req_raw_c  = req_gate_c ? la_data_in[REQ_BIT] : sync_q[0];
  assign req_s_c    = sync_q[SYNC_STG-1];

  assign sum_c     = {1'b0, acc_q} + {1'b0, opd_q};
  // Counter value as of this edge, which is what CNT_READ / CNT_STOP report.
  assign cnt_inc_c = cnt_en_q ? cnt_q + DATA_W'(1) : cnt_q;

  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      req_seen_q <= 1'b0;
      op_q       <= '0;
      opd_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      cnt_en_q   <= 1'b0;
      ckpt_q     <= '0;
      ckpt_oe_q  <= 1'b0;
      result_q   <= '0;
      status_q   <= '0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_STG-2:0], req_raw_c};
      req_seen_q <= req_seen_d;
      op_q       <= op_d;
      opd_q      <= opd_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      cnt_en_q   <= cnt_en_d;
      ckpt_q     <= ckpt_d;
      ckpt_oe_q  <= ckpt_oe_d;
      result_q   <= result_d;
      status_q   <= status_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_seen_d = req_seen_q;
    op_d       = op_q;
    opd_d      = opd_q;
    acc_d      = acc_q;
    cnt_d      = cnt_inc_c;
    cnt_en_d   = cnt_en_q;
    ckpt_d     = ckpt_q;
    ckpt_oe_d  = ckpt_oe_q;
    result_d   = result_q;
    status_d   = status_q;
    ack_d      = ack_q;

    unique case (state_q)
      IDLE: begin
        if (req_s_c != req_seen_q) begin
          req_seen_d = req_s_c;
          op_d       = la_data_in[OP_LSB +: OP_W];
          opd_d      = la_data_in[DATA_W-1:0];
          state_d    = EXEC;
        end
      end
      EXEC: begin
        status_d = ST_OK;
        state_d  = RESP;
        unique case (op_q)
          OP_NOP, OP_READ: result_d = acc_q;
          OP_LOAD: begin
            acc_d    = opd_q;
            result_d = opd_q;
          end
          OP_ADD: begin
            acc_d    = sum_c[DATA_W-1:0];
            result_d = sum_c[DATA_W-1:0];
            status_d = sum_c[DATA_W] ? ST_OVF : ST_OK;
          end
          OP_CNT_START: begin
            cnt_d    = '0;
            cnt_en_d = 1'b1;
            result_d = '0;
          end
          OP_CNT_STOP: begin
            cnt_en_d = 1'b0;
            result_d = cnt_inc_c;
          end
          OP_CNT_READ: result_d = cnt_inc_c;
          OP_CKPT: begin
            ckpt_d    = opd_q[CKPT_W-1:0];
            ckpt_oe_d = 1'b1;
            result_d  = opd_q;
          end
          default: begin
            result_d = acc_q;
            status_d = ST_BADOP;
          end
        endcase
      end
      RESP: begin
        ack_d   = ~ack_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_comb begin
    la_data_out                      = '0;
    la_data_out[DATA_W-1:0]          = result_q;
    la_data_out[OP_LSB +: ST_W]      = status_q;
    la_data_out[REQ_BIT]             = ack_q;
    la_data_out[BUSY_BIT]            = busy_q;
  end

  always_comb begin
    io_out                      = '0;
    io_out[CKPT_LSB +: CKPT_W]  = ckpt_q;
    io_oeb                      = '1;
    if (ckpt_oe_q) io_oeb[CKPT_LSB +: CKPT_W] = '0;
  end

endmodule

// File: tb/tb_la_mailbox_responder.sv
// Bench for la_mailbox_responder: directed vector table, multi-cycle corner sequences and
// randomized commands scored against an edge-counting behavioural model.
module tb_la_mailbox_responder;

  logic         wb_clk_i = 1'b0;
  logic         resetb   = 1'b0;
  logic [127:0] la_data_in;
  logic [127:0] la_oenb;
  logic [127:0] la_data_out;
  logic [37:0]  io_out;
  logic [37:0]  io_oeb;

  la_mailbox_responder dut (
    .wb_clk_i   (wb_clk_i),
    .resetb     (resetb),
    .la_data_in (la_data_in),
    .la_oenb    (la_oenb),
    .la_data_out(la_data_out),
    .io_out     (io_out),
    .io_oeb     (io_oeb)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int edge_cnt = 0;
  always @(posedge wb_clk_i) edge_cnt <= edge_cnt + 1;

  int   checks = 0;
  int   errors = 0;
  logic req_tgl = 1'b0;
  int   last_exec;

  // Reference state: plain values plus the edge at which the counter was started.
  logic [31:0] m_acc;
  logic [15:0] m_ckpt;
  logic        m_oe;
  logic        m_run;
  longint      m_start;
  logic [31:0] m_frozen;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] opd;
    logic [31:0] res;
    logic [3:0]  st;
    logic [15:0] ckpt;
    logic        oe;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_io(input string name, input logic [15:0] ckpt, input logic oe);
    logic [37:0] e_out, e_oeb;
    e_out = '0;
    e_out[31:16] = ckpt;
    e_oeb = '1;
    if (oe) e_oeb[31:16] = '0;
    chk({name, "_io_out"}, 128'(io_out), 128'(e_out));
    chk({name, "_io_oeb"}, 128'(io_oeb), 128'(e_oeb));
  endtask

  task automatic model_reset();
    m_acc = '0; m_ckpt = '0; m_oe = 1'b0; m_run = 1'b0; m_start = 0; m_frozen = '0;
  endtask

  task automatic model_cmd(input logic [3:0] op, input logic [31:0] opd, input int exec,
                           output logic [31:0] res, output logic [3:0] st);
    logic [32:0] sum;
    st = 4'd0;
    case (op)
      4'd0, 4'd3: res = m_acc;
      4'd1: begin m_acc = opd; res = opd; end
      4'd2: begin
        sum = {1'b0, m_acc} + {1'b0, opd};
        m_acc = sum[31:0]; res = sum[31:0]; st = {3'b0, sum[32]};
      end
      4'd4: begin m_run = 1'b1; m_start = longint'(exec); res = '0; end
      4'd5: begin
        if (m_run) m_frozen = 32'(longint'(exec) - m_start);
        m_run = 1'b0; res = m_frozen;
      end
      4'd6: res = m_run ? 32'(longint'(exec) - m_start) : m_frozen;
      4'd7: begin m_ckpt = opd[15:0]; m_oe = 1'b1; res = opd; end
      default: begin res = m_acc; st = 4'd2; end
    endcase
  endtask

  // Issue one command and wait (bounded) for its ack; ack must land 4 edges after the req edge.
  task automatic do_cmd(input logic [3:0] op, input logic [31:0] opd,
                        output logic [31:0] res, output logic [3:0] st);
    logic ack0;
    int   e0;
    bit   got;
    @(negedge wb_clk_i);
    ack0 = la_data_out[36];
    la_data_in[31:0]  = opd;
    la_data_in[35:32] = op;
    req_tgl = ~req_tgl;
    la_data_in[36] = req_tgl;
    e0 = edge_cnt + 1;
    last_exec = e0 + 3;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge wb_clk_i);
      if (la_data_out[36] != ack0) got = 1'b1;
    end
    chk("ack_latency", 128'(edge_cnt), 128'(e0 + 4));
    res = la_data_out[31:0];
    st  = la_data_out[35:32];
  endtask

  initial begin
    logic [31:0] res, exp_res, r1, r2;
    logic [3:0]  st, exp_st;
    logic        ack0;
    int          t;

    vecs[0] = '{4'd1, 32'h0000_1234, 32'h0000_1234, 4'd0, 16'h0000, 1'b0};
    vecs[1] = '{4'd3, 32'h0000_0000, 32'h0000_1234, 4'd0, 16'h0000, 1'b0};
    vecs[2] = '{4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd0, 16'h0000, 1'b0};
    vecs[3] = '{4'd2, 32'h0000_0002, 32'h0000_0001, 4'd1, 16'h0000, 1'b0};
    vecs[4] = '{4'd3, 32'h0000_0000, 32'h0000_0001, 4'd0, 16'h0000, 1'b0};
    vecs[5] = '{4'd7, 32'h0000_AB60, 32'h0000_AB60, 4'd0, 16'hAB60, 1'b1};
    vecs[6] = '{4'd7, 32'h0000_AB61, 32'h0000_AB61, 4'd0, 16'hAB61, 1'b1};
    vecs[7] = '{4'd1, 32'h0000_0055, 32'h0000_0055, 4'd0, 16'hAB61, 1'b1};
    vecs[8] = '{4'd15, 32'h1234_5678, 32'h0000_0055, 4'd2, 16'hAB61, 1'b1};
    vecs[9] = '{4'd3, 32'h0000_0000, 32'h0000_0055, 4'd0, 16'hAB61, 1'b1};

    la_data_in = '0;
    la_data_in[127:64] = {$urandom, $urandom};
    la_oenb = '0;
    la_oenb[127:37] = '1;
    model_reset();

    repeat (3) @(negedge wb_clk_i);
    chk("reset_la_out", la_data_out, '0);
    chk_io("reset", 16'h0, 1'b0);
    resetb = 1'b1;
    repeat (2) @(negedge wb_clk_i);

    for (int i = 0; i < 10; i++) begin
      do_cmd(vecs[i].op, vecs[i].opd, res, st);
      chk($sformatf("vec%0d_result", i), 128'(res), 128'(vecs[i].res));
      chk($sformatf("vec%0d_status", i), 128'(st), 128'(vecs[i].st));
      chk_io($sformatf("vec%0d", i), vecs[i].ckpt, vecs[i].oe);
    end
    m_acc = 32'h55; m_ckpt = 16'hAB61; m_oe = 1'b1;

    // Toggle with the command field not owned by mgmt: must be ignored.
    ack0 = la_data_out[36];
    @(negedge wb_clk_i);
    la_oenb[36] = 1'b1;
    la_data_in[36] = ~req_tgl;
    repeat (50) @(negedge wb_clk_i);
    chk("oenb_no_ack", 128'(la_data_out[36]), 128'(ack0));
    chk("oenb_not_busy", 128'(la_data_out[37]), 128'(0));
    la_data_in[36] = req_tgl;
    @(negedge wb_clk_i);
    la_oenb[36] = 1'b0;
    repeat (10) @(negedge wb_clk_i);
    chk("oenb_restore_no_ack", 128'(la_data_out[36]), 128'(ack0));

    // Counter read exactly 100 edges after start.
    do_cmd(4'd4, 32'h0, res, st);
    model_cmd(4'd4, 32'h0, last_exec, exp_res, exp_st);
    chk("cnt_start_result", 128'(res), 128'(0));
    t = last_exec;
    while (edge_cnt < t + 95) @(negedge wb_clk_i);
    do_cmd(4'd6, 32'h0, res, st);
    model_cmd(4'd6, 32'h0, last_exec, exp_res, exp_st);
    chk("cnt_read_100", 128'(res), 128'(100));
    do_cmd(4'd5, 32'h0, r1, st);
    model_cmd(4'd5, 32'h0, last_exec, exp_res, exp_st);
    chk("cnt_stop_model", 128'(r1), 128'(exp_res));
    repeat (7) @(negedge wb_clk_i);
    do_cmd(4'd6, 32'h0, r2, st);
    model_cmd(4'd6, 32'h0, last_exec, exp_res, exp_st);
    chk("cnt_read_after_stop", 128'(r2), 128'(exp_res));

    for (int i = 0; i < 200; i++) begin
      logic [3:0]  op;
      logic [31:0] opd;
      op  = 4'($urandom_range(0, 15));
      opd = (($urandom & 3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom & 15) : $urandom;
      repeat ($urandom_range(0, 3)) @(negedge wb_clk_i);
      do_cmd(op, opd, res, st);
      model_cmd(op, opd, last_exec, exp_res, exp_st);
      chk($sformatf("rand%0d_op%0d_result", i, op), 128'(res), 128'(exp_res));
      chk($sformatf("rand%0d_op%0d_status", i, op), 128'(st), 128'(exp_st));
      chk_io($sformatf("rand%0d", i), m_ckpt, m_oe);
    end

    // Reset while a LOAD is in EXEC: command dropped, everything cleared.
    @(negedge wb_clk_i);
    la_data_in[31:0]  = 32'h77;
    la_data_in[35:32] = 4'd1;
    req_tgl = ~req_tgl;
    la_data_in[36] = req_tgl;
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    chk("pre_reset_busy", 128'(la_data_out[37]), 128'(1));
    resetb = 1'b0;
    #1;
    chk("midreset_la_out", la_data_out, '0);
    chk_io("midreset", 16'h0, 1'b0);
    req_tgl = 1'b0;
    la_data_in[36] = 1'b0;
    model_reset();
    repeat (3) @(negedge wb_clk_i);
    resetb = 1'b1;
    repeat (10) @(negedge wb_clk_i);
    chk("post_reset_no_ack", la_data_out, '0);
    do_cmd(4'd3, 32'h0, res, st);
    chk("post_reset_read", 128'(res), 128'(0));
    chk("post_reset_status", 128'(st), 128'(0));
    chk_io("post_reset", 16'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
